// File: rtl/scoreboard_hazard_unit.sv
// scoreboard_hazard_unit
//   ID-stage hazard detector with an internal scoreboard of in-flight multiplies.
//   Raises Stall for these cases:
//     - load-use
//     - mul RAW
//     - mul-vs-branch RAW
//     - WAW against a pending mul
//     - writeback-port collision between a single-cycle op and a mul
//   PCWrite and IDWrite are the inverse of Stall.
//
//   Ports:
//     clk, rst                     clock, async active-high reset
//     id_valid, flush              ID instruction valid / squashed
//     Rs1, Rs2, Rd                 ID register indices
//     RegWrite, Branch, IsMul      ID instruction class
//     E_Rd, E_MemRead              EX destination and load flag
//     PCWrite, IDWrite, Stall      pipeline control (combinational)
//     mul_busy                     any multiply still in flight
//   Optional (HAZARD_PERF_CNT_EN):
//     stall_cnt                    saturating count of stall cycles
//     stall_why                    cause vector {wbport,waw,mubr,raw,load} of the last stall
//
//   Parameters:
//     MUL_LAT must lie in 2..16 and must exceed WB_DIST.

// Compares one scoreboard slot against the ID operands.
module sb_slot_cmp #(
  parameter int REG_W = 5
) (
  input  logic             vld,
  input  logic [REG_W-1:0] rd,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic [REG_W-1:0] id_rd,
  output logic             hit_rs,
  output logic             hit_rd
);
  assign hit_rs = vld && (((rd == rs1) && (rs1 != '0)) || ((rd == rs2) && (rs2 != '0)));
  assign hit_rd = vld && (rd == id_rd) && (id_rd != '0);
endmodule

module scoreboard_hazard_unit #(
  parameter int REG_W   = 5,
  parameter int MUL_LAT = 5,
  parameter int WB_DIST = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic             flush,
  input  logic [REG_W-1:0] Rs1,
  input  logic [REG_W-1:0] Rs2,
  input  logic [REG_W-1:0] Rd,
  input  logic             RegWrite,
  input  logic             Branch,
  input  logic             IsMul,
  input  logic [REG_W-1:0] E_Rd,
  input  logic             E_MemRead,
  output logic             PCWrite,
  output logic             IDWrite,
  output logic             Stall,
  output logic             mul_busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]      stall_cnt,
  output logic [4:0]       stall_why
`endif
);
  // Slot p holds a mul that writes back MUL_LAT-1-p cycles from now.
  logic [MUL_LAT-1:0]            sb_vld;
  logic [MUL_LAT-1:0][REG_W-1:0] sb_rd;
  logic [MUL_LAT-1:0]            hit_rs, hit_rd;

  for (genvar p = 0; p < MUL_LAT; p++) begin : g_slot
    sb_slot_cmp #(.REG_W(REG_W)) u_cmp (
      .vld   (sb_vld[p]),
      .rd    (sb_rd[p]),
      .rs1   (Rs1),
      .rs2   (Rs2),
      .id_rd (Rd),
      .hit_rs(hit_rs[p]),
      .hit_rd(hit_rd[p])
    );
  end

  logic qual, single_wr;
  logic load_h, raw_h, mubr_h, waw_h, wbp_h, push;

  // Reset also gates the load check, which is otherwise purely combinational.
  assign qual      = id_valid && !flush && !rst;
  assign single_wr = RegWrite && !IsMul;

  assign load_h = qual && E_MemRead && (E_Rd != '0) && ((E_Rd == Rs1) || (E_Rd == Rs2));

  // The last slot is writing this cycle; the write-through regfile covers
  // ALU operands, but the ID branch comparator has no mul bypass.
  assign raw_h  = qual && (|hit_rs[MUL_LAT-2:0]);
  assign mubr_h = qual && Branch && hit_rs[MUL_LAT-1];
  assign waw_h  = qual && single_wr && (|hit_rd);

  // This slot's mul reaches WB in WB_DIST cycles, the same cycle as an op issued now.
  assign wbp_h  = qual && single_wr && sb_vld[MUL_LAT-1-WB_DIST];

  assign Stall    = load_h || raw_h || mubr_h || waw_h || wbp_h;
  assign PCWrite  = !Stall;
  assign IDWrite  = !Stall;
  assign mul_busy = |sb_vld;

  assign push = id_valid && IsMul && RegWrite && !flush && !Stall && (Rd != '0);

  // The mul pipe never stalls, so the scoreboard shifts every edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_vld <= '0;
      sb_rd  <= '0;
    end else begin
      sb_vld <= {sb_vld[MUL_LAT-2:0], push};
      sb_rd  <= {sb_rd[MUL_LAT-2:0], Rd};
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      stall_why <= '0;
    end else if (Stall) begin
      if (stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
      stall_why <= {wbp_h, waw_h, mubr_h, raw_h, load_h};
    end
  end
`endif

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// Bench for scoreboard_hazard_unit.
//   Each cycle the expected control vector {Stall,PCWrite,IDWrite,mul_busy} is
//   computed from a list of in-flight multiplies tracked by age. It is queued
//   when inputs are driven, then popped and compared on the falling edge.
//   Directed cases also check stall lengths against fixed constants.
module tb_scoreboard_hazard_unit;
  localparam int REG_W   = 5;
  localparam int MUL_LAT = 5;
  localparam int WB_DIST = 3;

  logic clk = 1'b0;
  logic rst;
  logic id_valid, flush, RegWrite, Branch, IsMul, E_MemRead;
  logic [REG_W-1:0] Rs1, Rs2, Rd, E_Rd;
  logic PCWrite, IDWrite, Stall, mul_busy;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [4:0]  stall_why;
`endif

  always #5 clk = ~clk;

  scoreboard_hazard_unit #(.REG_W(REG_W), .MUL_LAT(MUL_LAT), .WB_DIST(WB_DIST)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .flush(flush),
    .Rs1(Rs1), .Rs2(Rs2), .Rd(Rd), .RegWrite(RegWrite), .Branch(Branch), .IsMul(IsMul),
    .E_Rd(E_Rd), .E_MemRead(E_MemRead),
    .PCWrite(PCWrite), .IDWrite(IDWrite), .Stall(Stall), .mul_busy(mul_busy)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .stall_why(stall_why)
`endif
  );

  int total = 0;
  int bad   = 0;
  int mdl_cnt = 0;

  typedef struct {
    logic [REG_W-1:0] rd;
    int               age;
  } ent_t;
  ent_t       fl[$];
  logic [3:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected stall, reasoned from each pending mul's distance to writeback.
  function automatic logic mdl_stall();
    logic h, src;
    int   wb_in;
    h = E_MemRead && (E_Rd != 0) && ((E_Rd == Rs1) || (E_Rd == Rs2));
    foreach (fl[i]) begin
      wb_in = MUL_LAT - 1 - fl[i].age;
      src   = (fl[i].rd == Rs1) || (fl[i].rd == Rs2);
      if (src && wb_in > 0) h = 1'b1;
      if (src && Branch && wb_in == 0) h = 1'b1;
      if (RegWrite && !IsMul && ((fl[i].rd == Rd) || (wb_in == WB_DIST))) h = 1'b1;
    end
    return id_valid && !flush && h;
  endfunction

  task automatic age_model();
    ent_t nq[$];
    foreach (fl[i])
      if (fl[i].age < MUL_LAT - 1) nq.push_back('{rd: fl[i].rd, age: fl[i].age + 1});
    fl = nq;
  endtask

  // One cycle: drive at posedge+1, compare at negedge, advance model at posedge.
  task automatic cyc(input logic v, input logic fl_i, input logic rw, input logic br,
                     input logic im, input logic mr,
                     input logic [REG_W-1:0] s1, input logic [REG_W-1:0] s2,
                     input logic [REG_W-1:0] d, input logic [REG_W-1:0] ed,
                     output logic st);
    logic e_st, e_push;
    logic [3:0] e;
    id_valid = v; flush = fl_i; RegWrite = rw; Branch = br; IsMul = im; E_MemRead = mr;
    Rs1 = s1; Rs2 = s2; Rd = d; E_Rd = ed;
    e_st = mdl_stall();
    exp_q.push_back({e_st, !e_st, !e_st, fl.size() != 0});
    @(negedge clk);
    e = exp_q.pop_front();
    chk("ctl", {28'd0, Stall, PCWrite, IDWrite, mul_busy}, {28'd0, e});
    st = Stall;
    e_push = v && im && rw && !fl_i && !e_st && (d != 0);
    if (e_st) mdl_cnt++;
    @(posedge clk);
    age_model();
    if (e_push) fl.push_back('{rd: d, age: 0});
    #1;
  endtask

  task automatic nop(input int n);
    logic st;
    repeat (n) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, st);
  endtask

  initial begin
    logic st;
    int   n;
    rst = 1'b1;
    id_valid = 0; flush = 0; RegWrite = 0; Branch = 0; IsMul = 0; E_MemRead = 1;
    Rs1 = 5; Rs2 = 0; Rd = 0; E_Rd = 5;
    // Load hazard present on the inputs, but reset holds control released.
    id_valid = 1;
    @(negedge clk);
    chk("rst_ctl", {28'd0, Stall, PCWrite, IDWrite, mul_busy}, 32'h6);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: load-use
    cyc(1, 0, 1, 0, 0, 1, 5, 0, 6, 5, st);  chk("t1_ld_stall", {31'd0, st}, 1);
    cyc(1, 0, 1, 0, 0, 0, 5, 0, 6, 5, st);  chk("t1_ld_clear", {31'd0, st}, 0);

    // 2: mul x7 then add reading x7
    cyc(1, 0, 1, 0, 1, 0, 1, 2, 7, 0, st);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      cyc(1, 0, 1, 0, 0, 0, 1, 7, 8, 0, st);
      if (!st) break;
      n++;
    end
    chk("t2_raw_len", n, 4);
    nop(MUL_LAT);

    // 3: mul x7 then branch on x7
    cyc(1, 0, 1, 0, 1, 0, 1, 2, 7, 0, st);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      cyc(1, 0, 0, 1, 0, 0, 7, 0, 0, 0, st);
      if (!st) break;
      n++;
    end
    chk("t3_mubr_len", n, 5);
    nop(MUL_LAT);

    // 4: mul x9 then add writing x9
    cyc(1, 0, 1, 0, 1, 0, 1, 2, 9, 0, st);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      cyc(1, 0, 1, 0, 0, 0, 1, 2, 9, 0, st);
      if (!st) break;
      n++;
    end
    chk("t4_waw_len", n, 5);
    nop(MUL_LAT);

    // 5: mul x3, gap, then unrelated add x4 lands on the mul's WB cycle
    cyc(1, 0, 1, 0, 1, 0, 1, 2, 3, 0, st);
    nop(1);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      cyc(1, 0, 1, 0, 0, 0, 1, 2, 4, 0, st);
      if (!st) break;
      n++;
    end
    chk("t5_wbport_len", n, 1);
    nop(MUL_LAT);

    // 6: flush with a hazard present, then async reset with two muls pending
    cyc(1, 1, 1, 0, 1, 1, 5, 0, 6, 5, st);  chk("t6_flush_stall", {31'd0, st}, 0);
    nop(1);
    cyc(1, 0, 1, 0, 1, 0, 1, 2, 3, 0, st);
    cyc(1, 0, 1, 0, 1, 0, 1, 2, 4, 0, st);
    id_valid = 1; flush = 0; RegWrite = 1; Branch = 0; IsMul = 0; E_MemRead = 0;
    Rs1 = 4; Rs2 = 3; Rd = 8; E_Rd = 0;
    #1;
    chk("t6_pre_stall", {31'd0, Stall}, 1);
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_ctl", {28'd0, Stall, PCWrite, IDWrite, mul_busy}, 32'h6);
    fl.delete();
    mdl_cnt = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    nop(1);

    // Random traffic against the model
    for (int k = 0; k < 300; k++) begin
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 2) != 0,
          $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
          REG_W'($urandom_range(0, 3)), REG_W'($urandom_range(0, 3)),
          REG_W'($urandom_range(0, 3)), REG_W'($urandom_range(0, 3)), st);
    end
    nop(2);

`ifdef HAZARD_PERF_CNT_EN
    chk("perf_cnt", stall_cnt, mdl_cnt);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
